// File: rtl/flash_reader_pkg.sv
// Shared definitions for the SPI flash read controller.
//   - opcode constants for the fast-read (1-1-1) and quad-output (1-1-4) reads
//   - FSM state enumeration used by flash_reader
package flash_pkg;

   localparam logic [7:0] OPC_FAST_READ = 8'h0B;
   localparam logic [7:0] OPC_QUAD_READ = 8'h6B;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      DUMMY,
      DATA,
      WAIT_OUT,
      CS_HOLD
   } state_t;

endpackage

// File: rtl/flash_reader_if.sv
// Bus between the flash read controller and the existing serial (SPI) engine.
//   master : controller side (issues q_start with a transfer description)
//   slave  : serial engine side (returns completion strobes and received byte)
// Signals:
//   q_start        one-cycle transfer launch
//   q_qio_mode     receive on four data lines
//   q_dummy        transfer is dummy clocks only
//   q_delay_cycle  extra sampling delay (unused, tied low by the controller)
//   q_tx_data      shifted out MSB first, q_tx_size bits
//   q_rx_size      bits to receive (or dummy clocks when q_dummy=1)
//   q_rx_data      last received byte
//   q_tx_complete  one-cycle strobe at end of transmit
//   q_rx_complete  one-cycle strobe at end of receive
interface flash_reader_if;

   logic        q_start;
   logic        q_qio_mode;
   logic        q_dummy;
   logic        q_delay_cycle;
   logic [31:0] q_tx_data;
   logic [5:0]  q_tx_size;
   logic [3:0]  q_rx_size;
   logic [7:0]  q_rx_data;
   logic        q_tx_complete;
   logic        q_rx_complete;

   modport master (
      output q_start, q_qio_mode, q_dummy, q_delay_cycle,
             q_tx_data, q_tx_size, q_rx_size,
      input  q_rx_data, q_tx_complete, q_rx_complete
   );

   modport slave (
      input  q_start, q_qio_mode, q_dummy, q_delay_cycle,
             q_tx_data, q_tx_size, q_rx_size,
      output q_rx_data, q_tx_complete, q_rx_complete
   );

endinterface

// File: rtl/flash_reader.sv
// SPI flash read sequencer. Accepts a (addr, len) read request, drives cs_n and
// the serial engine through command, dummy and data phases, and streams the
// received bytes to a valid/ready consumer. Backpressure simply stops issuing
// byte transfers, which parks the SPI clock with cs_n still low.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   req, addr, len      read request (len=0 completes immediately)
//   busy, done          controller active / one-cycle completion pulse
//   out_data, out_valid, out_ready   received byte stream
//   cs_n                flash chip select
//   spi                 serial engine bus (flash_reader_if.master)
//
// Build option: FLASH_READER_QUAD_EN selects quad-output fast read (0x6B,
// data phase on four lines); otherwise plain fast read (0x0B).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | cs_n high, waiting for req
// CMD      | opcode + address being shifted out
// DUMMY    | dummy clocks running
// DATA     | one byte being received
// WAIT_OUT | byte presented on out_data, waiting for out_ready
// CS_HOLD  | cs_n high recovery time, done on the final cycle
module flash_reader
   import flash_pkg::*;
#(
   parameter int ADDR_WIDTH     = 24,
   parameter int LEN_WIDTH      = 16,
   parameter int DUMMY_CYCLES   = 8,
   parameter int CS_HIGH_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [LEN_WIDTH-1:0]  len,
   output logic                  busy,
   output logic                  done,
   output logic [7:0]            out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  cs_n,
   flash_reader_if.master        spi
);

`ifdef FLASH_READER_QUAD_EN
   localparam logic [7:0] OPCODE   = OPC_QUAD_READ;
   localparam logic       DATA_QIO = 1'b1;
`else
   localparam logic [7:0] OPCODE   = OPC_FAST_READ;
   localparam logic       DATA_QIO = 1'b0;
`endif

   localparam logic [5:0] CMD_BITS   = 6'(8 + ADDR_WIDTH);
   localparam logic [3:0] DUMMY_SIZE = 4'(DUMMY_CYCLES);
   localparam logic [3:0] BYTE_BITS  = 4'd8;
   localparam int         HOLD_W     = (CS_HIGH_CYCLES > 1) ? $clog2(CS_HIGH_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(CS_HIGH_CYCLES - 1);

   state_t               state_q, state_d;
   logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
   logic [HOLD_W-1:0]    hold_q, hold_d;
   logic                 cs_n_q, cs_n_d;
   logic [7:0]           out_data_q, out_data_d;
   logic                 out_valid_q, out_valid_d;
   logic                 start_q, start_d;
   logic [31:0]          tx_data_q, tx_data_d;
   logic [5:0]           tx_size_q, tx_size_d;
   logic [3:0]           rx_size_q, rx_size_d;
   logic                 qio_q, qio_d;
   logic                 dummy_q, dummy_d;
   logic                 zero_done_q, zero_done_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         hold_q      <= '0;
         cs_n_q      <= 1'b1;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         start_q     <= 1'b0;
         tx_data_q   <= '0;
         tx_size_q   <= '0;
         rx_size_q   <= '0;
         qio_q       <= 1'b0;
         dummy_q     <= 1'b0;
         zero_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         hold_q      <= hold_d;
         cs_n_q      <= cs_n_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         start_q     <= start_d;
         tx_data_q   <= tx_data_d;
         tx_size_q   <= tx_size_d;
         rx_size_q   <= rx_size_d;
         qio_q       <= qio_d;
         dummy_q     <= dummy_d;
         zero_done_q <= zero_done_d;
      end
   end

   // All engine controls are registered together with q_start, so a launch is
   // always seen by the engine with a consistent transfer description and
   // q_start can never be high on two consecutive cycles.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      hold_d      = hold_q;
      cs_n_d      = cs_n_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      start_d     = 1'b0;
      tx_data_d   = tx_data_q;
      tx_size_d   = tx_size_q;
      rx_size_d   = rx_size_q;
      qio_d       = qio_q;
      dummy_d     = dummy_q;
      zero_done_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (req) begin
               if (len != '0) begin
                  remaining_d = len;
                  cs_n_d      = 1'b0;
                  start_d     = 1'b1;
                  tx_data_d   = 32'({OPCODE, addr});
                  tx_size_d   = CMD_BITS;
                  rx_size_d   = '0;
                  qio_d       = 1'b0;
                  dummy_d     = 1'b0;
                  state_d     = CMD;
               end else begin
                  zero_done_d = 1'b1;
               end
            end
         end

         CMD: begin
            if (spi.q_tx_complete) begin
               start_d   = 1'b1;
               tx_size_d = '0;
               rx_size_d = DUMMY_SIZE;
               qio_d     = 1'b0;
               dummy_d   = 1'b1;
               state_d   = DUMMY;
            end
         end

         DUMMY: begin
            if (spi.q_rx_complete) begin
               start_d   = 1'b1;
               tx_size_d = '0;
               rx_size_d = BYTE_BITS;
               qio_d     = DATA_QIO;
               dummy_d   = 1'b0;
               state_d   = DATA;
            end
         end

         DATA: begin
            if (spi.q_rx_complete) begin
               out_data_d  = spi.q_rx_data;
               out_valid_d = 1'b1;
               remaining_d = remaining_q - 1'b1;
               state_d     = WAIT_OUT;
            end
         end

         WAIT_OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               if (remaining_q != '0) begin
                  start_d   = 1'b1;
                  tx_size_d = '0;
                  rx_size_d = BYTE_BITS;
                  qio_d     = DATA_QIO;
                  dummy_d   = 1'b0;
                  state_d   = DATA;
               end else begin
                  cs_n_d  = 1'b1;
                  hold_d  = HOLD_LOAD;
                  state_d = CS_HOLD;
               end
            end
         end

         CS_HOLD: begin
            if (hold_q == '0) begin
               state_d = IDLE;
            end else begin
               hold_d = hold_q - 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign busy      = (state_q != IDLE);
   assign done      = zero_done_q | ((state_q == CS_HOLD) && (hold_q == '0));
   assign cs_n      = cs_n_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;

   assign spi.q_start       = start_q;
   assign spi.q_tx_data     = tx_data_q;
   assign spi.q_tx_size     = tx_size_q;
   assign spi.q_rx_size     = rx_size_q;
   assign spi.q_qio_mode    = qio_q;
   assign spi.q_dummy       = dummy_q;
   assign spi.q_delay_cycle = 1'b0;

endmodule

// File: tb/tb_flash_reader.sv
`timescale 1ns/1ps
module tb_flash_reader;

   localparam int AW    = 24;
   localparam int LW    = 16;
   localparam int DUMMY = 8;
   localparam int CSH   = 4;

`ifdef FLASH_READER_QUAD_EN
   localparam logic [7:0] EXP_OPC   = 8'h6B;
   localparam logic       EXP_QIO   = 1'b1;
   localparam int         DATA_CLKS = 2;
`else
   localparam logic [7:0] EXP_OPC   = 8'h0B;
   localparam logic       EXP_QIO   = 1'b0;
   localparam int         DATA_CLKS = 8;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req = 1'b0;
   logic [AW-1:0] addr = '0;
   logic [LW-1:0] len = '0;
   logic          busy, done, out_valid, cs_n;
   logic          out_ready = 1'b0;
   logic [7:0]    out_data;

   flash_reader_if spi();

   flash_reader #(
      .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DUMMY_CYCLES(DUMMY), .CS_HIGH_CYCLES(CSH)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .addr(addr), .len(len),
      .busy(busy), .done(done), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .cs_n(cs_n), .spi(spi)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Flash contents and scoreboard queues
   logic [7:0]  mem [256];
   logic [31:0] cmd_q[$];
   logic [7:0]  byte_q[$];
   int          done_cnt = 0;

   // ---------------- serial engine + flash model ----------------
   int         e_cnt   = 0;
   bit         e_busy  = 0;
   bit         e_prev_start = 0;
   int         e_phase = 0;   // 0: expect command, 1: expect dummy, 2: data
   int         e_kind  = 0;   // kind of running transfer: 0 cmd, 1 dummy, 2 data
   logic [7:0] e_addr  = '0;

   initial begin
      bit was_busy;
      spi.q_tx_complete = 1'b0;
      spi.q_rx_complete = 1'b0;
      spi.q_rx_data     = 8'h00;
      forever begin
         @(negedge clk);
         spi.q_tx_complete = 1'b0;
         spi.q_rx_complete = 1'b0;
         if (reset) begin
            e_busy = 0; e_phase = 0; e_prev_start = 0;
         end else begin
            if (cs_n) e_phase = 0;
            was_busy = e_busy;
            if (e_busy) begin
               e_cnt--;
               if (e_cnt <= 0) begin
                  e_busy = 0;
                  if (e_kind == 0) spi.q_tx_complete = 1'b1;
                  else begin
                     spi.q_rx_complete = 1'b1;
                     if (e_kind == 1) spi.q_rx_data = 8'($urandom);
                     else begin
                        spi.q_rx_data = mem[e_addr];
                        e_addr++;
                     end
                  end
               end
            end
            if (spi.q_start) begin
               check("start_while_busy", 32'(was_busy), 0);
               check("start_back_to_back", 32'(e_prev_start), 0);
               check("q_delay_cycle", 32'(spi.q_delay_cycle), 0);
               check("cs_n_low_at_start", 32'(cs_n), 0);
               if (spi.q_tx_size != 0) begin
                  check("phase_cmd", e_phase, 0);
                  check("cmd_expected", 32'(cmd_q.size() != 0), 1);
                  if (cmd_q.size() != 0) check("q_tx_data", spi.q_tx_data, cmd_q.pop_front());
                  check("cmd_tx_size", 32'(spi.q_tx_size), AW + 8);
                  check("cmd_rx_size", 32'(spi.q_rx_size), 0);
                  check("cmd_qio", 32'(spi.q_qio_mode), 0);
                  e_addr  = spi.q_tx_data[7:0];
                  e_cnt   = int'(spi.q_tx_size);
                  e_kind  = 0;
                  e_phase = 1;
               end else if (spi.q_dummy) begin
                  check("phase_dummy", e_phase, 1);
                  check("dummy_rx_size", 32'(spi.q_rx_size), DUMMY);
                  check("dummy_qio", 32'(spi.q_qio_mode), 0);
                  e_cnt   = int'(spi.q_rx_size);
                  e_kind  = 1;
                  e_phase = 2;
               end else begin
                  check("phase_data", e_phase, 2);
                  check("data_rx_size", 32'(spi.q_rx_size), 8);
                  check("data_qio", 32'(spi.q_qio_mode), 32'(EXP_QIO));
                  e_cnt = spi.q_qio_mode ? int'(spi.q_rx_size) / 4 : int'(spi.q_rx_size);
                  check("data_spi_clocks", e_cnt, DATA_CLKS);
                  e_kind = 2;
               end
               if (e_cnt < 1) e_cnt = 1;
               e_busy = 1;
            end
            e_prev_start = spi.q_start;
         end
      end
   end

   // ---------------- output monitor ----------------
   initial begin
      bit         prev_valid = 0, prev_ready = 0, xfer_active = 0;
      logic [7:0] prev_data = '0;
      int         cs_hi_run = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_valid = 0; xfer_active = 0; cs_hi_run = 0;
         end else begin
            if (out_valid && prev_valid && !prev_ready)
               check("out_data_stable", out_data, prev_data);
            if (out_valid && out_ready) begin
               check("byte_expected", 32'(byte_q.size() != 0), 1);
               if (byte_q.size() != 0) check("out_data", out_data, byte_q.pop_front());
            end
            if (cs_n) cs_hi_run++;
            else begin
               cs_hi_run = 0; xfer_active = 1;
            end
            if (done) begin
               done_cnt++;
               if (xfer_active) begin
                  check("cs_high_cycles", cs_hi_run, CSH);
                  xfer_active = 0;
               end
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_data  = out_data;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic start_read(input logic [AW-1:0] a, input logic [LW-1:0] n);
      @(posedge clk); #1;
      req = 1'b1; addr = a; len = n;
      if (n != 0) begin
         cmd_q.push_back({EXP_OPC, a});
         for (int i = 0; i < int'(n); i++) byte_q.push_back(mem[8'(a + i)]);
      end
      @(posedge clk); #1;
      req = 1'b0;
   endtask

   task automatic wait_done(input bit rand_ready);
      bit got = 0;
      for (int i = 0; i < 3000 && !got; i++) begin
         @(posedge clk); #1;
         if (done) got = 1;
         else if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      end
      check("done_seen", 32'(got), 1);
      @(negedge clk); #1;
   endtask

   initial begin
      int d0;
      bit found;
      logic [7:0] held;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_cs_n", 32'(cs_n), 1);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_data", 32'(out_data), 0);
      check("rst_q_start", 32'(spi.q_start), 0);
      check("rst_q_dummy", 32'(spi.q_dummy), 0);
      reset = 1'b0;

      // Basic 3-byte read with known contents
      mem[8'h45] = 8'hA5; mem[8'h46] = 8'h5A; mem[8'h47] = 8'hFF;
      out_ready = 1'b1;
      d0 = done_cnt;
      start_read(24'h012345, 3);
      check("busy_in_xfer", 32'(busy), 1);
      wait_done(0);
      check("done_pulses_basic", done_cnt - d0, 1);
      check("bytes_left_basic", byte_q.size(), 0);

      // Zero length: done one cycle after req, no chip select activity
      d0 = done_cnt;
      start_read(24'h000100, 0);
      check("zero_len_done", 32'(done), 1);
      check("zero_len_busy", 32'(busy), 0);
      repeat (6) begin
         @(posedge clk); #1;
         check("zero_len_cs_n", 32'(cs_n), 1);
         check("zero_len_q_start", 32'(spi.q_start), 0);
      end
      check("done_pulses_zero", done_cnt - d0, 1);

      // Backpressure after first byte
      out_ready = 1'b0;
      d0 = done_cnt;
      start_read(24'h00A0F0, 2);
      found = 0;
      for (int i = 0; i < 1000 && !found; i++) begin
         @(posedge clk); #1;
         if (out_valid) found = 1;
      end
      check("first_byte_valid", 32'(found), 1);
      held = out_data;
      repeat (20) begin
         @(posedge clk); #1;
         check("bp_data_held", out_data, held);
         check("bp_valid_held", 32'(out_valid), 1);
         check("bp_cs_n_low", 32'(cs_n), 0);
         check("bp_spi_idle", 32'(e_busy), 0);
      end
      out_ready = 1'b1;
      wait_done(0);
      check("done_pulses_bp", done_cnt - d0, 1);
      check("bytes_left_bp", byte_q.size(), 0);

      // Reset during data phase
      d0 = done_cnt;
      start_read(24'h003300, 4);
      found = 0;
      for (int i = 0; i < 1000 && !found; i++) begin
         @(posedge clk); #1;
         if (e_busy && e_kind == 2) found = 1;
      end
      check("reached_data_phase", 32'(found), 1);
      reset = 1'b1;
      byte_q.delete();
      cmd_q.delete();
      @(posedge clk); #1;
      check("abort_cs_n", 32'(cs_n), 1);
      check("abort_out_valid", 32'(out_valid), 0);
      check("abort_busy", 32'(busy), 0);
      reset = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      check("abort_no_done", done_cnt - d0, 0);
      d0 = done_cnt;
      start_read(24'h0033A0, 1);
      wait_done(0);
      check("done_pulses_after_abort", done_cnt - d0, 1);
      check("bytes_left_after_abort", byte_q.size(), 0);

      // req while busy is ignored
      d0 = done_cnt;
      start_read(24'h004410, 3);
      repeat (5) @(posedge clk);
      #1;
      check("busy_mid_xfer", 32'(busy), 1);
      req = 1'b1; addr = 24'h00FF00; len = 16'd5;
      @(posedge clk); #1;
      req = 1'b0;
      wait_done(0);
      check("done_pulses_busy_req", done_cnt - d0, 1);
      check("bytes_left_busy_req", byte_q.size(), 0);
      check("cmds_left_busy_req", cmd_q.size(), 0);

      // Randomized reads with random backpressure
      d0 = done_cnt;
      for (int t = 0; t < 20; t++) begin
         start_read(AW'($urandom), LW'($urandom_range(1, 6)));
         wait_done(1);
         out_ready = 1'b1;
      end
      check("done_pulses_random", done_cnt - d0, 20);
      check("bytes_left_random", byte_q.size(), 0);
      check("cmds_left_random", cmd_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
